load_store_unit: RTL and testbench

Memory-stage load/store unit between the EX/MEM pipeline register and `Data_Memory`. It converts RV32I byte, halfword and word accesses into word-only accesses on the data memory port. Loads are extracted and sign- or zero-extended for the MEM/WB register. Sub-word stores are performed as a two-cycle read-modify-write, and the unit stalls the upstream pipeline for one cycle while the read half completes.

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage load/store unit for an RV32I pipeline. It turns
//               byte, halfword and word accesses into word-only accesses on
//               a single data-memory port.
//               - Loads: byte or halfword lane selection, then sign or zero
//                 extension, all in the same cycle.
//               - sw: written in a single cycle.
//               - sb/sh: two-cycle read-modify-write that stalls upstream
//                 for the read cycle.
//               - Misaligned or unsupported accesses do nothing and set a
//                 sticky error flag.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               MemRead/MemWrite  - load / store request from EX/MEM
//               funct3            - access type (size and signedness)
//               ALUresult         - byte address
//               StoreData         - rs2 value to store
//               dm_MemRead/Write  - data-memory enables (never both high)
//               dm_Addr           - word-aligned data-memory address
//               dm_WriteData      - word written to data memory
//               dm_ReadData       - combinational read word from data memory
//               LoadData          - extended load result to MEM/WB
//               Stall             - hold EX/MEM and earlier stages
//               MisalignedErr     - sticky misaligned/unsupported flag
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUresult,
    input  logic [31:0] StoreData,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    output logic [31:0] dm_Addr,
    output logic [31:0] dm_WriteData,
    input  logic [31:0] dm_ReadData,
    output logic [31:0] LoadData,
    output logic        Stall,
    output logic        MisalignedErr
);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] old_word_q;
    logic [29:0] addr_q;        // word address of the pending RMW
    logic [1:0]  lane_q;        // byte offset of the pending RMW
    logic        half_q;        // 1: halfword store, 0: byte store
    logic [15:0] store_q;
    logic        err_q;

    logic [1:0]  w_off;
    logic        w_load_bad;
    logic        w_store_bad;
    logic        w_err_set;
    logic        w_rmw_start;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged;

    assign w_off = ALUresult[1:0];

    // Access legality: unsupported encodings and natural-alignment violations.
    always_comb begin
        w_load_bad = 1'b0;
        case (funct3)
            c_f3_b, c_f3_bu: w_load_bad = 1'b0;
            c_f3_h, c_f3_hu: w_load_bad = w_off[0];
            c_f3_w:          w_load_bad = (w_off != 2'b00);
            default:         w_load_bad = 1'b1;
        endcase
        w_store_bad = 1'b0;
        case (funct3)
            c_f3_b:  w_store_bad = 1'b0;
            c_f3_h:  w_store_bad = w_off[0];
            c_f3_w:  w_store_bad = (w_off != 2'b00);
            default: w_store_bad = 1'b1;
        endcase
    end

    // Lane selection from the read word for loads.
    always_comb begin
        w_byte = dm_ReadData[7:0];
        case (w_off)
            2'd0:    w_byte = dm_ReadData[7:0];
            2'd1:    w_byte = dm_ReadData[15:8];
            2'd2:    w_byte = dm_ReadData[23:16];
            default: w_byte = dm_ReadData[31:24];
        endcase
        w_half = w_off[1] ? dm_ReadData[31:16] : dm_ReadData[15:0];
    end

    // Old word with the latched lane replaced; used only in RMW_WRITE.
    always_comb begin
        w_merged = old_word_q;
        if (half_q) begin
            w_merged[{lane_q[1], 4'b0000} +: 16] = store_q;
        end else begin
            w_merged[{lane_q, 3'b000} +: 8] = store_q[7:0];
        end
    end

    // Next-state and combinational port logic. Everything is gated by rst so
    // that no memory enable can fire while reset is held.
    always_comb begin
        state_d      = state_q;
        dm_MemRead   = 1'b0;
        dm_MemWrite  = 1'b0;
        dm_Addr      = {ALUresult[31:2], 2'b00};
        dm_WriteData = StoreData;
        LoadData     = 32'h0;
        Stall        = 1'b0;
        w_err_set    = 1'b0;
        w_rmw_start  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (MemRead) begin
                        if (w_load_bad) begin
                            w_err_set = 1'b1;
                        end else begin
                            dm_MemRead = 1'b1;
                            case (funct3)
                                c_f3_b:  LoadData = {{24{w_byte[7]}}, w_byte};
                                c_f3_bu: LoadData = {24'h0, w_byte};
                                c_f3_h:  LoadData = {{16{w_half[15]}}, w_half};
                                c_f3_hu: LoadData = {16'h0, w_half};
                                default: LoadData = dm_ReadData;
                            endcase
                        end
                    end else if (MemWrite) begin
                        if (w_store_bad) begin
                            w_err_set = 1'b1;
                        end else if (funct3 == c_f3_w) begin
                            dm_MemWrite = 1'b1;
                        end else begin
                            // Sub-word store: read the old word this cycle.
                            dm_MemRead  = 1'b1;
                            Stall       = 1'b1;
                            w_rmw_start = 1'b1;
                            state_d     = RMW_WRITE;
                        end
                    end
                end
                RMW_WRITE: begin
                    // Current request inputs are the held instruction; ignore.
                    dm_MemWrite  = 1'b1;
                    dm_Addr      = {addr_q, 2'b00};
                    dm_WriteData = w_merged;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            old_word_q <= 32'h0;
            addr_q     <= 30'h0;
            lane_q     <= 2'b00;
            half_q     <= 1'b0;
            store_q    <= 16'h0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_err_set) begin
                err_q <= 1'b1;
            end
            if (w_rmw_start) begin
                old_word_q <= dm_ReadData;
                addr_q     <= ALUresult[31:2];
                lane_q     <= w_off;
                half_q     <= (funct3 == c_f3_h);
                store_q    <= StoreData[15:0];
            end
        end
    end

    assign MisalignedErr = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. A behavioural word
//               memory answers the DUT; the driver predicts each memory-port
//               transaction from a reference copy of memory and queues it;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ALUresult = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        dm_MemRead, dm_MemWrite, Stall, MisalignedErr;
    logic [31:0] dm_Addr, dm_WriteData, dm_ReadData, LoadData;

    load_store_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .funct3       (funct3),
        .ALUresult    (ALUresult),
        .StoreData    (StoreData),
        .dm_MemRead   (dm_MemRead),
        .dm_MemWrite  (dm_MemWrite),
        .dm_Addr      (dm_Addr),
        .dm_WriteData (dm_WriteData),
        .dm_ReadData  (dm_ReadData),
        .LoadData     (LoadData),
        .Stall        (Stall),
        .MisalignedErr(MisalignedErr)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on rising edge.
    logic [31:0] mem [0:15];
    assign dm_ReadData = mem[dm_Addr[5:2]];
    always @(posedge clk) begin
        if (dm_MemWrite) mem[dm_Addr[5:2]] <= dm_WriteData;
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [0:15];
    bit          ref_err = 1'b0;
    int          exp_stalls = 0;
    int          stall_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (Stall) stall_cnt <= stall_cnt + 1;
    end

    // Monitor: every memory-port transaction must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (dm_MemRead && dm_MemWrite) check("port_conflict", 32'd1, 32'd0);
            if (dm_MemWrite || (dm_MemRead && !Stall)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_dm_access", {dm_MemWrite, dm_Addr[30:0]}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.is_wr) begin
                        check("wr_kind", {31'h0, dm_MemWrite}, 32'd1);
                        check("wr_addr", dm_Addr, e.addr);
                        check("wr_data", dm_WriteData, e.data);
                    end else begin
                        check("ld_kind", {31'h0, dm_MemRead && !dm_MemWrite}, 32'd1);
                        check("ld_addr", dm_Addr, e.addr);
                        check("ld_data", LoadData, e.data);
                    end
                end
            end else if (LoadData != 32'h0) begin
                check("loaddata_idle", LoadData, 32'h0);
            end
        end
    end

    // Reference rules written from the ISA description of each access.
    function automatic bit access_bad(input bit is_load, input logic [2:0] f3, input logic [1:0] a);
        if (is_load) begin
            if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
            if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
            if (f3 == 2 && a != 0) return 1'b1;
            return 1'b0;
        end
        if (f3 > 2) return 1'b1;
        if (f3 == 1 && a[0]) return 1'b1;
        if (f3 == 2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    // Present one instruction, predict its effect, and let it complete.
    task automatic issue(input bit mr, input bit mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
        int   ncyc;
        int   wi;
        exp_t e;
        logic [31:0] mask;
        wi   = int'(addr[5:2]);
        ncyc = 1;
        MemRead = mr; MemWrite = mw; funct3 = f3; ALUresult = addr; StoreData = sd;
        if (mr || mw) begin
            if (access_bad(mr, f3, addr[1:0])) begin
                ref_err = 1'b1;
            end else if (mr) begin
                e.is_wr = 1'b0; e.addr = {addr[31:2], 2'b00};
                e.data  = ref_load(ref_mem[wi], f3, addr[1:0]);
                sb_q.push_back(e);
            end else begin
                e.is_wr = 1'b1; e.addr = {addr[31:2], 2'b00};
                if (f3 == 3'd2) begin
                    e.data = sd;
                end else begin
                    mask = (f3 == 3'd0) ? (32'hFF << (8 * addr[1:0]))
                                        : (32'hFFFF << (16 * addr[1]));
                    e.data = (ref_mem[wi] & ~mask) | ((sd << (f3 == 3'd0 ? 8 * addr[1:0] : 16 * addr[1])) & mask);
                    ncyc = 2;
                    exp_stalls++;
                end
                ref_mem[wi] = e.data;
                sb_q.push_back(e);
            end
        end
        repeat (ncyc) @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("err_flag", {31'h0, MisalignedErr}, {31'h0, ref_err});
        check("stall_count", stall_cnt, exp_stalls);
    endtask

    task automatic do_reset();
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; ALUresult = 32'h0;
        @(negedge clk);
        check("rst_dm_read", {31'h0, dm_MemRead}, 32'd0);
        check("rst_dm_write", {31'h0, dm_MemWrite}, 32'd0);
        check("rst_stall", {31'h0, Stall}, 32'd0);
        check("rst_loaddata", LoadData, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0;
        ref_err = 1'b0;
        check("rst_err", {31'h0, MisalignedErr}, 32'd0);
    endtask

    initial begin
        int b2b_start;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        @(posedge clk); #1;
        do_reset();

        // Fill memory with known values through the DUT.
        for (int i = 0; i < 16; i++) issue(0, 1, 3'd2, i * 4, $urandom);

        // Load extension on word 4.
        issue(0, 1, 3'd2, 32'h10, 32'h80FF_1234);
        issue(1, 0, 3'd0, 32'h13, 0);
        issue(1, 0, 3'd4, 32'h13, 0);
        issue(1, 0, 3'd1, 32'h12, 0);
        issue(1, 0, 3'd5, 32'h10, 0);
        issue(1, 0, 3'd2, 32'h10, 0);

        // sb read-modify-write, then read back.
        issue(0, 1, 3'd2, 32'h0, 32'h0000_0015);
        issue(0, 1, 3'd0, 32'h2, 32'h0000_00AB);
        issue(1, 0, 3'd2, 32'h0, 0);

        // sh and sw.
        issue(0, 1, 3'd2, 32'h4, 32'd50);
        issue(0, 1, 3'd1, 32'h6, 32'h0000_BEEF);
        issue(0, 1, 3'd2, 32'h8, 32'hDEAD_BEEF);
        issue(1, 0, 3'd2, 32'h4, 0);
        issue(1, 0, 3'd2, 32'h8, 0);

        // Back-to-back sb into the same word.
        issue(0, 1, 3'd2, 32'h0, 32'h0);
        b2b_start = stall_cnt;
        issue(0, 1, 3'd0, 32'h0, 32'h11);
        issue(0, 1, 3'd0, 32'h1, 32'h22);
        check("b2b_stalls", stall_cnt - b2b_start, 2);
        issue(1, 0, 3'd2, 32'h0, 0);

        // Reset asserted in RMW_WRITE suppresses the write.
        issue(0, 1, 3'd2, 32'h0, 32'h0000_0015);
        MemWrite = 1'b1; funct3 = 3'd0; ALUresult = 32'h0; StoreData = 32'hFF;
        exp_stalls++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_no_write", {31'h0, dm_MemWrite}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; MemWrite = 1'b0;
        check("rmw_rst_word", mem[0], 32'h0000_0015);
        check("rmw_rst_err", {31'h0, MisalignedErr}, 32'd0);
        issue(1, 0, 3'd2, 32'h0, 0);

        // Misaligned accesses: no port activity, sticky flag.
        issue(1, 0, 3'd2, 32'h1, 0);
        issue(0, 1, 3'd1, 32'h3, 32'h1234);
        issue(1, 0, 3'd0, 32'h4, 0);
        issue(0, 0, 3'd0, 32'h0, 0);
        check("err_sticky", {31'h0, MisalignedErr}, 32'd1);
        do_reset();

        // Randomized mix, biased towards legal accesses.
        for (int n = 0; n < 300; n++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] ad;
            ld = $urandom_range(0, 1);
            f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 8) begin
                if (f3 == 3'd2) ad[1:0] = 2'b00;
                if (f3 == 3'd1 || f3 == 3'd5) ad[0] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) issue(0, 0, f3, ad, $urandom);
            else issue(ld, !ld, f3, ad, $urandom);
        end

        @(posedge clk); #1;
        check("queue_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
